wait_state_memory: RTL and testbench

WAIT_STATE_MEMORY -- requirements
Module: wait_state_memory

---
 rtl/wsm_pkg.sv | 18 +
 rtl/wsm_sram.sv | 26 ++
 rtl/wait_state_memory.sv | 86 ++++++++
 tb/tb_wait_state_memory.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/wsm_pkg.sv
// Shared types and defaults for the wait-state memory slice.
package wsm_pkg;

    localparam int unsigned LATENCY_DEFAULT    = 2;
    localparam int unsigned DEPTH_LOG2_DEFAULT = 8;
    localparam int unsigned CNT_W              = 4;
    localparam int unsigned DATA_W             = 16;
    localparam int unsigned ADDR_W             = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/wsm_sram.sv
// Two-lane word storage: synchronous per-byte write, combinational read, no reset.
module wsm_sram
    import wsm_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
    input  logic                  i_clk,
    input  logic [DEPTH_LOG2-1:0] i_addr,
    input  logic [1:0]            i_we,
    input  logic [DATA_W-1:0]     i_wdata,
    output logic [DATA_W-1:0]     o_rdata_c
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [7:0] r_lane0 [DEPTH];
    logic [7:0] r_lane1 [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we[0]) r_lane0[i_addr] <= i_wdata[7:0];
        if (i_we[1]) r_lane1[i_addr] <= i_wdata[15:8];
    end

    assign o_rdata_c = {r_lane1[i_addr], r_lane0[i_addr]};

endmodule

// File: rtl/wait_state_memory.sv
// Memory with a fixed number of wait states between request acceptance and a one-cycle resp.
module wait_state_memory
    import wsm_pkg::*;
#(
    parameter int unsigned LATENCY    = LATENCY_DEFAULT,
    parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              read,
    input  logic              write,
    input  logic [1:0]        wmask,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] wdata,
    output logic              resp,
    output logic [DATA_W-1:0] rdata
);

    state_t              r_state;
    cnt_t                r_cnt;
    logic                r_op_write;
    logic                r_resp;
    logic [DATA_W-1:0]   r_rdata;

    logic                  w_req;
    logic                  w_done;
    logic [1:0]            w_we;
    logic [DEPTH_LOG2-1:0] w_index;
    logic [DATA_W-1:0]     w_sram_rdata;
    logic                  w_unused_addr;

    assign w_req   = read | write;
    // Completion happens on the edge that leaves BUSY with the request still held.
    assign w_done  = (r_state == BUSY) && w_req && (r_cnt == '0);
    assign w_we    = (w_done && r_op_write) ? wmask : 2'b00;
    assign w_index = address[DEPTH_LOG2:1];
    assign w_unused_addr = ^address;

    wsm_sram #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_sram (
        .i_clk     (clk),
        .i_addr    (w_index),
        .i_we      (w_we),
        .i_wdata   (wdata),
        .o_rdata_c (w_sram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_op_write <= 1'b0;
            r_resp     <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_resp <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_state    <= BUSY;
                        r_cnt      <= cnt_t'(LATENCY - 1);
                        r_op_write <= write;
                    end
                end
                BUSY: begin
                    if (!w_req) begin
                        r_state <= IDLE;
                    end else if (r_cnt == '0) begin
                        r_state <= RESP;
                        r_resp  <= 1'b1;
                        if (!r_op_write) r_rdata <= w_sram_rdata;
                    end else begin
                        r_cnt <= r_cnt - cnt_t'(1);
                    end
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign resp  = r_resp;
    assign rdata = r_rdata;

endmodule

// File: tb/tb_wait_state_memory.sv
// Directed and randomized checks of wait_state_memory against a word-array reference model.
module tb_wait_state_memory;

    localparam int unsigned LAT = 2;
    localparam int unsigned L1  = 1;
    localparam int unsigned DL2 = 8;
    localparam int unsigned NW  = 1 << DL2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [1:0]  wmask = 2'b00;
    logic [15:0] address = 16'h0;
    logic [15:0] wdata = 16'h0;
    logic        resp;
    logic [15:0] rdata;

    logic        l1_read = 1'b0;
    logic        l1_resp;
    logic [15:0] l1_rdata;

    int checks = 0;
    int failures = 0;

    logic [15:0] mem [NW];
    logic [15:0] exp_rdata = 16'h0;
    int          idx_set [16];

    always #5 clk = ~clk;

    wait_state_memory #(.LATENCY(LAT), .DEPTH_LOG2(DL2)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .read    (read),
        .write   (write),
        .wmask   (wmask),
        .address (address),
        .wdata   (wdata),
        .resp    (resp),
        .rdata   (rdata)
    );

    wait_state_memory #(.LATENCY(L1), .DEPTH_LOG2(DL2)) u_dut_l1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .read    (l1_read),
        .write   (1'b0),
        .wmask   (2'b00),
        .address (16'h0004),
        .wdata   (16'h0000),
        .resp    (l1_resp),
        .rdata   (l1_rdata)
    );

    function automatic int widx(input logic [15:0] a);
        return (int'(a) / 2) % NW;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge; returns just after a negedge with the bus idle.
    task automatic xact(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [15:0] wd, input logic [1:0] wm);
        int i;
        read = rd; write = wr; address = a; wdata = wd; wmask = wm;
        i = widx(a);
        if (wr) begin
            if (wm[0]) mem[i][7:0]  = wd[7:0];
            if (wm[1]) mem[i][15:8] = wd[15:8];
        end else begin
            exp_rdata = mem[i];
        end
        for (int j = 0; j <= int'(LAT); j++) begin
            @(posedge clk); #1;
            chk((j == int'(LAT)) ? "resp_pulse" : "resp_wait", 16'(resp),
                (j == int'(LAT)) ? 16'd1 : 16'd0);
        end
        chk(wr ? "rdata_hold_on_write" : "rdata_read", rdata, exp_rdata);
        @(negedge clk);
        read = 1'b0; write = 1'b0;
        @(posedge clk); #1;
        chk("resp_one_cycle", 16'(resp), 16'd0);
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_resp", 16'(resp), 16'd0);
        chk("rst_rdata", rdata, 16'h0000);
        chk("rst_l1_resp", 16'(l1_resp), 16'd0);
        rst_n = 1'b1;

        // Basic write then read, accepted on first edge after release
        xact(1'b0, 1'b1, 16'h0010, 16'h1234, 2'b11);
        xact(1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00);
        chk("basic_read", rdata, 16'h1234);

        // Byte lanes
        xact(1'b0, 1'b1, 16'h0010, 16'hABCD, 2'b01);
        xact(1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00);
        chk("lane0_read", rdata, 16'h12CD);
        xact(1'b0, 1'b1, 16'h0010, 16'hABCD, 2'b10);
        xact(1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00);
        chk("lane1_read", rdata, 16'hABCD);

        // Read and write together behave as a write
        xact(1'b1, 1'b1, 16'h0020, 16'h5555, 2'b11);
        xact(1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00);
        chk("both_high_read", rdata, 16'h5555);

        // Abort by dropping write in BUSY
        xact(1'b0, 1'b1, 16'h0040, 16'h1111, 2'b11);
        write = 1'b1; address = 16'h0040; wdata = 16'hFFFF; wmask = 2'b11;
        @(posedge clk); #1;
        chk("abort_accept_resp", 16'(resp), 16'd0);
        @(negedge clk);
        write = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(posedge clk); #1;
            chk("abort_no_resp", 16'(resp), 16'd0);
        end
        chk("abort_rdata_kept", rdata, exp_rdata);
        @(negedge clk);
        xact(1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00);
        chk("abort_word_kept", rdata, 16'h1111);

        // Reset while BUSY on a write: no commit, no resp, rdata cleared
        write = 1'b1; address = 16'h0010; wdata = 16'hDEAD; wmask = 2'b11;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_resp", 16'(resp), 16'd0);
        chk("midrst_rdata", rdata, 16'h0000);
        exp_rdata = 16'h0000;
        @(negedge clk);
        write = 1'b0;
        @(posedge clk); #1;
        chk("midrst_resp_held", 16'(resp), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        xact(1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00);
        chk("midrst_no_commit", rdata, 16'hABCD);

        // Address aliasing
        xact(1'b0, 1'b1, 16'h0202, 16'h7777, 2'b11);
        xact(1'b1, 1'b0, 16'h0002, 16'h0000, 2'b00);
        chk("alias_read", rdata, 16'h7777);

        // Randomized traffic over a fixed word set, with random aliasing bits
        for (int k = 0; k < 16; k++) begin
            idx_set[k] = (k * 13 + 5) % NW;
            xact(1'b0, 1'b1, {7'($urandom), 8'(idx_set[k]), 1'($urandom)},
                 16'($urandom), 2'b11);
        end
        for (int n = 0; n < 40; n++) begin
            logic [15:0] a;
            int          op;
            a  = {7'($urandom), 8'(idx_set[$urandom_range(15, 0)]), 1'($urandom)};
            op = int'($urandom_range(2, 0));
            xact(op != 1, op != 0, a, 16'($urandom), 2'($urandom));
        end

        // LATENCY=1 with read held continuously: accept, resp, idle, repeat
        l1_read = 1'b1;
        for (int e = 0; e < 12; e++) begin
            @(posedge clk); #1;
            chk("l1_b2b_resp", 16'(l1_resp),
                ((e % int'(L1 + 2)) == int'(L1)) ? 16'd1 : 16'd0);
        end
        @(negedge clk);
        l1_read = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
